// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: data word, ALU selectors, opcodes,
// immediate formats and the registered decode bundle.
package decode_stage_pkg;

    typedef logic [31:0] word;

    typedef enum logic {
        ALU_RS1_OP = 1'b0,
        ALU_PC_OP  = 1'b1
    } alu_rs1_t;

    typedef enum logic {
        ALU_RS2_OP = 1'b0,
        ALU_IMM_OP = 1'b1
    } alu_rs2_t;

    typedef enum logic [3:0] {
        NO_ALU_OP   = 4'd0,
        OP_ALU_ADD  = 4'd1,
        OP_ALU_SUB  = 4'd2,
        OP_ALU_SLL  = 4'd3,
        OP_ALU_SLT  = 4'd4,
        OP_ALU_SLTU = 4'd5,
        OP_ALU_XOR  = 4'd6,
        OP_ALU_SRL  = 4'd7,
        OP_ALU_SRA  = 4'd8,
        OP_ALU_OR   = 4'd9,
        OP_ALU_AND  = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        word      imm;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic     rd_we;
        alu_rs1_t alu_rs1;
        alu_rs2_t alu_rs2;
        alu_op_t  alu_op_code;
        logic     is_load;
        logic     is_store;
        logic     is_branch;
        logic     is_jump;
        logic [2:0] funct3;
        logic     illegal;
    } dec_bundle_t;

    localparam dec_bundle_t BUNDLE_RST = '{
        imm:         32'd0,
        rs1_addr:    5'd0,
        rs2_addr:    5'd0,
        rd_addr:     5'd0,
        rd_we:       1'b0,
        alu_rs1:     ALU_RS1_OP,
        alu_rs2:     ALU_RS2_OP,
        alu_op_code: NO_ALU_OP,
        is_load:     1'b0,
        is_store:    1'b0,
        is_branch:   1'b0,
        is_jump:     1'b0,
        funct3:      3'd0,
        illegal:     1'b0
    };

    // Base funct3 -> ALU op mapping shared by OP and OP-IMM.
    function automatic alu_op_t f3_to_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ALU_ADD;
            3'b001:  return OP_ALU_SLL;
            3'b010:  return OP_ALU_SLT;
            3'b011:  return OP_ALU_SLTU;
            3'b100:  return OP_ALU_XOR;
            3'b101:  return OP_ALU_SRL;
            3'b110:  return OP_ALU_OR;
            default: return OP_ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction; all formats sign-extend from instr[31].
module imm_gen
    import decode_stage_pkg::*;
(
    input  word      instr,
    input  imm_fmt_t fmt,
    output word      imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// One-entry registered RV32I decode stage with valid/ready handshake and flush.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  word        instr,
    input  word        pc_in,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output word        pc_out,
    output word        imm,
    output logic [4:0] rs1_addr,
    output logic [4:0] rs2_addr,
    output logic [4:0] rd_addr,
    output logic       rd_we,
    output alu_rs1_t   alu_rs1,
    output alu_rs2_t   alu_rs2,
    output alu_op_t    alu_op_code,
    output logic       is_load,
    output logic       is_store,
    output logic       is_branch,
    output logic       is_jump,
    output logic [2:0] funct3,
    output logic       illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    imm_fmt_t    fmt;
    word         gen_imm;
    dec_bundle_t dec;
    dec_bundle_t bundle_q;
    word         pc_q;
    logic        valid_q;
    logic        accept;
    logic        legal;
    logic        we;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        fmt = IMM_NONE;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                      fmt = IMM_S;
            OPC_BRANCH:                     fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
            OPC_JAL:                        fmt = IMM_J;
            default:                        fmt = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (instr),
        .fmt   (fmt),
        .imm   (gen_imm)
    );

    always_comb begin
        dec          = BUNDLE_RST;
        dec.rs1_addr = instr[19:15];
        dec.rs2_addr = instr[24:20];
        dec.rd_addr  = instr[11:7];
        dec.funct3   = f3;
        legal        = 1'b1;
        we           = 1'b0;
        if (instr[1:0] != 2'b11) begin
            legal = 1'b0;
        end else begin
            case (opcode)
                OPC_OP: begin
                    we = 1'b1;
                    if (f7 == F7_BASE)                    dec.alu_op_code = f3_to_alu(f3);
                    else if (f7 == F7_ALT && f3 == 3'b000) dec.alu_op_code = OP_ALU_SUB;
                    else if (f7 == F7_ALT && f3 == 3'b101) dec.alu_op_code = OP_ALU_SRA;
                    else                                  legal = 1'b0;
                end
                OPC_OP_IMM: begin
                    we          = 1'b1;
                    dec.alu_rs2 = ALU_IMM_OP;
                    if (f3 == 3'b001) begin
                        if (f7 == F7_BASE) dec.alu_op_code = OP_ALU_SLL;
                        else               legal = 1'b0;
                    end else if (f3 == 3'b101) begin
                        if (f7 == F7_BASE)     dec.alu_op_code = OP_ALU_SRL;
                        else if (f7 == F7_ALT) dec.alu_op_code = OP_ALU_SRA;
                        else                   legal = 1'b0;
                    end else begin
                        dec.alu_op_code = f3_to_alu(f3);
                    end
                end
                // ALU just forwards the immediate for LUI
                OPC_LUI: begin
                    we          = 1'b1;
                    dec.alu_rs2 = ALU_IMM_OP;
                end
                OPC_AUIPC, OPC_JAL: begin
                    we              = 1'b1;
                    dec.alu_rs1     = ALU_PC_OP;
                    dec.alu_rs2     = ALU_IMM_OP;
                    dec.alu_op_code = OP_ALU_ADD;
                    dec.is_jump     = (opcode == OPC_JAL);
                end
                OPC_LOAD, OPC_STORE, OPC_JALR: begin
                    we              = (opcode != OPC_STORE);
                    dec.alu_rs2     = ALU_IMM_OP;
                    dec.alu_op_code = OP_ALU_ADD;
                    dec.is_load     = (opcode == OPC_LOAD);
                    dec.is_store    = (opcode == OPC_STORE);
                    dec.is_jump     = (opcode == OPC_JALR);
                end
                OPC_BRANCH: begin
                    dec.is_branch = 1'b1;
                    case (f3)
                        3'b000, 3'b001: dec.alu_op_code = OP_ALU_SUB;
                        3'b100, 3'b101: dec.alu_op_code = OP_ALU_SLT;
                        3'b110, 3'b111: dec.alu_op_code = OP_ALU_SLTU;
                        default:        legal = 1'b0;
                    endcase
                end
                default: legal = 1'b0;
            endcase
        end
        if (!legal) begin
            dec.alu_rs1     = ALU_RS1_OP;
            dec.alu_rs2     = ALU_RS2_OP;
            dec.alu_op_code = NO_ALU_OP;
            dec.is_load     = 1'b0;
            dec.is_store    = 1'b0;
            dec.is_branch   = 1'b0;
            dec.is_jump     = 1'b0;
            we              = 1'b0;
        end
        dec.imm     = legal ? gen_imm : '0;
        dec.illegal = !legal;
        dec.rd_we   = we && (instr[11:7] != 5'd0);
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Payload only loads on accept, so a stalled bundle holds stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= BUNDLE_RST;
            pc_q     <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
            pc_q     <= pc_in;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign pc_out      = pc_q;
    assign imm         = bundle_q.imm;
    assign rs1_addr    = bundle_q.rs1_addr;
    assign rs2_addr    = bundle_q.rs2_addr;
    assign rd_addr     = bundle_q.rd_addr;
    assign rd_we       = bundle_q.rd_we;
    assign alu_rs1     = bundle_q.alu_rs1;
    assign alu_rs2     = bundle_q.alu_rs2;
    assign alu_op_code = bundle_q.alu_op_code;
    assign is_load     = bundle_q.is_load;
    assign is_store    = bundle_q.is_store;
    assign is_branch   = bundle_q.is_branch;
    assign is_jump     = bundle_q.is_jump;
    assign funct3      = bundle_q.funct3;
    assign illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of hand-decoded instructions through a scoreboard,
// plus stall, flush and reset sequences.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct packed {
        word        pc;
        word        imm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        alu_rs1_t   a1;
        alu_rs2_t   a2;
        alu_op_t    op;
        logic       ld;
        logic       st;
        logic       br;
        logic       jp;
        logic [2:0] f3;
        logic       ill;
    } bundle_t;

    typedef struct {
        word     instr;
        bundle_t exp;
        string   name;
    } vec_t;

    typedef struct {
        bundle_t b;
        string   name;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst, in_valid, flush, out_ready;
    logic       in_ready, out_valid;
    word        instr, pc_in, pc_out, imm;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic       rd_we, is_load, is_store, is_branch, is_jump, illegal;
    alu_rs1_t   alu_rs1;
    alu_rs2_t   alu_rs2;
    alu_op_t    alu_op_code;
    logic [2:0] funct3;

    int      n_checks = 0;
    int      n_errors = 0;
    bundle_t act;
    bundle_t cur_exp;
    string   cur_name;
    sb_t     sb[$];
    vec_t    vecs[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc_in       (pc_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pc_out      (pc_out),
        .imm         (imm),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (rd_addr),
        .rd_we       (rd_we),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_op_code (alu_op_code),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .funct3      (funct3),
        .illegal     (illegal)
    );

    always_comb begin
        act     = '0;
        act.pc  = pc_out;
        act.imm = imm;
        act.rs1 = rs1_addr;
        act.rs2 = rs2_addr;
        act.rd  = rd_addr;
        act.we  = rd_we;
        act.a1  = alu_rs1;
        act.a2  = alu_rs2;
        act.op  = alu_op_code;
        act.ld  = is_load;
        act.st  = is_store;
        act.br  = is_branch;
        act.jp  = is_jump;
        act.f3  = funct3;
        act.ill = illegal;
    end

    function automatic bundle_t mk(input word i, input logic [4:0] r1, input logic [4:0] r2,
                                   input logic [4:0] rd, input logic we, input alu_rs1_t a1,
                                   input alu_rs2_t a2, input alu_op_t op, input logic [3:0] cls,
                                   input logic [2:0] f3, input logic ill);
        bundle_t b;
        b     = '0;
        b.imm = i;
        b.rs1 = r1;
        b.rs2 = r2;
        b.rd  = rd;
        b.we  = we;
        b.a1  = a1;
        b.a2  = a2;
        b.op  = op;
        b.ld  = cls[3];
        b.st  = cls[2];
        b.br  = cls[1];
        b.jp  = cls[0];
        b.f3  = f3;
        b.ill = ill;
        return b;
    endfunction

    task automatic chk_bundle(input string nm, input bundle_t got, input bundle_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%b expected=%b", nm, got, exp);
        end
    endtask

    task automatic drive(input word ins, input word pc, input bundle_t e, input string nm);
        in_valid = 1'b1;
        instr    = ins;
        pc_in    = pc;
        cur_exp  = e;
        cur_exp.pc = pc;
        cur_name = nm;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk_bit("scoreboard_drained", sb.size() == 0, 1'b1);
    endtask

    // Accepts are pushed and outputs popped at the negedge before the edge that commits them.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got bundle %h, expected none", act);
                end else begin
                    sb_t item;
                    item = sb.pop_front();
                    chk_bundle(item.name, act, item.b);
                end
            end
            if (in_valid && in_ready && !flush) sb.push_back('{b: cur_exp, name: cur_name});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        bundle_t rst_exp;
        bundle_t a_exp;
        bundle_t b_exp;
        rst_exp = mk(0, 0, 0, 0, 0, ALU_RS1_OP, ALU_RS2_OP, NO_ALU_OP, 4'b0000, 0, 0);

        vecs.push_back('{32'h00500093, mk(32'd5,        0,  5,  1, 1, ALU_RS1_OP, ALU_IMM_OP, OP_ALU_ADD,  4'b0000, 0, 0), "addi"});
        vecs.push_back('{32'h402081B3, mk(32'd0,        1,  2,  3, 1, ALU_RS1_OP, ALU_RS2_OP, OP_ALU_SUB,  4'b0000, 0, 0), "sub"});
        vecs.push_back('{32'h123452B7, mk(32'h12345000, 8,  3,  5, 1, ALU_RS1_OP, ALU_IMM_OP, NO_ALU_OP,   4'b0000, 5, 0), "lui"});
        vecs.push_back('{32'hFE20CEE3, mk(32'hFFFFFFFC, 1,  2, 29, 0, ALU_RS1_OP, ALU_RS2_OP, OP_ALU_SLT,  4'b0010, 4, 0), "blt"});
        vecs.push_back('{32'h0020A423, mk(32'd8,        1,  2,  8, 0, ALU_RS1_OP, ALU_IMM_OP, OP_ALU_ADD,  4'b0100, 2, 0), "sw"});
        vecs.push_back('{32'hFFC0A203, mk(32'hFFFFFFFC, 1, 28,  4, 1, ALU_RS1_OP, ALU_IMM_OP, OP_ALU_ADD,  4'b1000, 2, 0), "lw_neg"});
        vecs.push_back('{32'hFF9FF0EF, mk(32'hFFFFFFF8,31, 25,  1, 1, ALU_PC_OP,  ALU_IMM_OP, OP_ALU_ADD,  4'b0001, 7, 0), "jal_neg"});
        vecs.push_back('{32'h000280E7, mk(32'd0,        5,  0,  1, 1, ALU_RS1_OP, ALU_IMM_OP, OP_ALU_ADD,  4'b0001, 0, 0), "jalr"});
        vecs.push_back('{32'h00208033, mk(32'd0,        1,  2,  0, 0, ALU_RS1_OP, ALU_RS2_OP, OP_ALU_ADD,  4'b0000, 0, 0), "add_x0"});
        vecs.push_back('{32'h40335293, mk(32'h00000403, 6,  3,  5, 1, ALU_RS1_OP, ALU_IMM_OP, OP_ALU_SRA,  4'b0000, 5, 0), "srai"});
        vecs.push_back('{32'h00001397, mk(32'h00001000, 0,  0,  7, 1, ALU_PC_OP,  ALU_IMM_OP, OP_ALU_ADD,  4'b0000, 1, 0), "auipc"});
        vecs.push_back('{32'h022081B3, mk(32'd0,        1,  2,  3, 0, ALU_RS1_OP, ALU_RS2_OP, NO_ALU_OP,   4'b0000, 0, 1), "op_bad_f7"});
        vecs.push_back('{32'h02109093, mk(32'd0,        1,  1,  1, 0, ALU_RS1_OP, ALU_RS2_OP, NO_ALU_OP,   4'b0000, 1, 1), "slli_bad_f7"});
        vecs.push_back('{32'h0020A063, mk(32'd0,        1,  2,  0, 0, ALU_RS1_OP, ALU_RS2_OP, NO_ALU_OP,   4'b0000, 2, 1), "branch_f3_010"});
        vecs.push_back('{32'hFFFFFFFF, mk(32'd0,       31, 31, 31, 0, ALU_RS1_OP, ALU_RS2_OP, NO_ALU_OP,   4'b0000, 7, 1), "all_ones"});
        vecs.push_back('{32'h00500090, mk(32'd0,        0,  5,  1, 0, ALU_RS1_OP, ALU_RS2_OP, NO_ALU_OP,   4'b0000, 0, 1), "low_bits_00"});

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; pc_in = '0; cur_exp = '0; cur_name = "";
        @(posedge clk);
        @(negedge clk);
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bundle("rst_outputs", act, rst_exp);
        @(posedge clk);
        #1 rst = 1'b0;

        // back-to-back table at full throughput
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].instr, 32'h100 + 32'(i) * 4, vecs[i].exp, vecs[i].name);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // two-cycle stall with a second instruction pending
        a_exp = vecs[0].exp; a_exp.pc = 32'h2000;
        b_exp = vecs[1].exp; b_exp.pc = 32'h2004;
        out_ready = 1'b0;
        drive(vecs[0].instr, 32'h2000, vecs[0].exp, "stall_a");
        @(posedge clk);
        #1 drive(vecs[1].instr, 32'h2004, vecs[1].exp, "stall_b");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_bit("stall_in_ready", in_ready, 1'b0);
            chk_bit("stall_out_valid", out_valid, 1'b1);
            chk_bundle("stall_hold", act, a_exp);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk_bit("after_stall_valid", out_valid, 1'b1);
        chk_bundle("after_stall_b", act, b_exp);
        drain();

        // flush with a same-cycle accept drops the instruction
        @(posedge clk);
        #1 drive(vecs[2].instr, 32'h3000, vecs[2].exp, "flush_accept");
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_bit("flush_accept_valid", out_valid, 1'b0);

        // flush of a stalled bundle
        @(posedge clk);
        #1 out_ready = 1'b0;
        drive(vecs[3].instr, 32'h3100, vecs[3].exp, "flush_held");
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk_bit("flush_held_valid", out_valid, 1'b0);
        chk_bit("flush_held_in_ready", in_ready, 1'b1);

        // reset mid-stall beats both flush and a pending accept
        @(posedge clk);
        #1 drive(vecs[4].instr, 32'h4000, vecs[4].exp, "rst_held");
        @(posedge clk);
        #1 drive(vecs[5].instr, 32'h4004, vecs[5].exp, "rst_incoming");
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_bit("midrst_out_valid", out_valid, 1'b0);
        chk_bit("midrst_in_ready", in_ready, 1'b1);
        chk_bundle("midrst_outputs", act, rst_exp);

        // stage still works after reset
        @(posedge clk);
        #1 drive(vecs[6].instr, 32'h5000, vecs[6].exp, "post_rst_jal");
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: none; data width is the package type word (32 bits).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  instruction/PC pair present.
REQ-006 in_ready  out  1  stage can accept this cycle.
REQ-007 instr  in  word  raw RV32I instruction.
REQ-008 pc_in  in  word  PC of instr.
REQ-009 flush  in  1  discard held and incoming instruction.
REQ-010 out_valid  out  1  decoded bundle valid.
REQ-011 out_ready  in  1  downstream accepts bundle.
REQ-012 pc_out  out  word  PC of decoded instruction.
REQ-013 imm  out  word  sign-extended immediate; 0 for R-type.
REQ-014 rs1_addr, rs2_addr, rd_addr  out  5 each  register indices.
REQ-015 rd_we  out  1  register writeback enable.
REQ-016 alu_rs1  out  alu_rs1_t  ALU_RS1_OP or ALU_PC_OP.
REQ-017 alu_rs2  out  alu_rs2_t  ALU_RS2_OP or ALU_IMM_OP.
REQ-018 alu_op_code  out  alu_op_t  ALU operation.
REQ-019 is_load, is_store, is_branch, is_jump  out  1 each  class flags.
REQ-020 funct3  out  3  instr[14:12] passthrough.
REQ-021 illegal  out  1  unsupported/malformed encoding.

Function
REQ-022 One-entry registered stage, latency 1: bundle appears the cycle after in_valid && in_ready.
REQ-023 in_ready = !out_valid || out_ready (combinational, no bubble at full throughput).
REQ-024 While out_valid && !out_ready, every output holds stable.
REQ-025 flush clears out_valid next cycle; flush wins over a same-cycle accept (instruction dropped).
REQ-026 Immediates: I, S, B, U (low 12 bits zero), J formats, sign-extended from instr[31].
REQ-027 OP/OP-IMM: funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; SUB only for OP with funct7=0100000, funct3=000; SRA/SRAI when funct7=0100000, funct3=101.
REQ-028 OP: funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101 -> illegal; OP-IMM shifts with funct7 not 0000000/0100000 -> illegal.
REQ-029 LUI: NO_ALU_OP (ALU forwards imm); AUIPC: ALU_PC_OP, ALU_IMM_OP, OP_ALU_ADD.
REQ-030 LOAD/STORE/JALR: ALU_RS1_OP, ALU_IMM_OP, OP_ALU_ADD; JAL: ALU_PC_OP, ALU_IMM_OP, OP_ALU_ADD.
REQ-031 BRANCH: ALU_RS2_OP; BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU; funct3 010/011 illegal.
REQ-032 rd_we=1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR, except rd_addr=0 forces rd_we=0.
REQ-033 illegal also for unknown opcode or instr[1:0]!=11; illegal bundle still emitted with rd_we=0, class flags 0, NO_ALU_OP.

Reset
REQ-034 On rst: out_valid=0, all data outputs 0, alu_op_code=NO_ALU_OP, alu_rs1=ALU_RS1_OP, alu_rs2=ALU_RS2_OP, illegal=0; in_ready=1 next cycle.
REQ-035 rst mid-stall discards the held bundle; rst dominates flush and accept.

Structure
REQ-036 Opcode constants and imm-format enum live in the params package beside word, alu_rs1_t, alu_rs2_t, alu_op_t.
REQ-037 Immediate extraction is sub-module imm_gen (combinational, instr + format -> word).

Verification
REQ-038 0x00500093 (addi x1,x0,5) -> next cycle imm=5, rd=1, rd_we=1, ALU_IMM_OP, OP_ALU_ADD.
REQ-039 0x402081B3 (sub x3,x1,x2) -> rs1=1, rs2=2, rd=3, OP_ALU_SUB, ALU_RS2_OP.
REQ-040 0x123452B7 (lui x5) -> imm=0x12345000, NO_ALU_OP, rd_we=1; 0xFE20CEE3 (blt) -> imm=0xFFFFFFFC, OP_ALU_SLT, is_branch=1, rd_we=0.
REQ-041 out_ready=0 two cycles with second instr pending -> outputs stable, in_ready=0; out_ready=1 -> second bundle next cycle.
REQ-042 0xFFFFFFFF -> illegal=1, rd_we=0; flush with accept in same cycle -> out_valid=0 next cycle.
